edge_monitor: RTL and testbench
===============================

EDGE_MONITOR -- requirements
Module: edge_monitor

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4, giving the number of independent input channels (minimum 1).
REQ-002 The block SHALL have parameter SYNC_LEVELS, default 2, giving the synchroniser flop depth per channel (minimum 2).
REQ-003 The block SHALL have parameter FILTER_CYCLES, default 4, giving the consecutive stable cycles needed to accept a level change (minimum 1).
REQ-004 The block SHALL have parameter CNT_WIDTH, default 8, giving the per-channel edge counter width (minimum 1).
REQ-005 The block SHALL have port clk_i, input, 1 bit: clock.
REQ-006 The block SHALL have port arst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port data_i, input, CHANNELS bits: asynchronous raw inputs.
REQ-008 The block SHALL have port mode_i, input, 2*CHANNELS bits: per-channel edge mode in bits [2c+1:2c]; 00 off, 01 rising, 10 falling, 11 both.
REQ-009 The block SHALL have port clear_i, input, CHANNELS bits: per-channel clear of pending and count.
REQ-010 The block SHALL have port data_o, output, CHANNELS bits: filtered, synchronised level.
REQ-011 The block SHALL have port edge_o, output, CHANNELS bits: one-cycle qualified-edge pulse.
REQ-012 The block SHALL have port pending_o, output, CHANNELS bits: sticky qualified-edge flag.
REQ-013 The block SHALL have port count_o, output, CHANNELS*CNT_WIDTH bits: saturating edge counts, channel c in bits [c*CNT_WIDTH +: CNT_WIDTH].
REQ-014 The block SHALL have port irq_o, output, 1 bit: OR of all pending_o bits.

Function
REQ-015 Each channel SHALL pass data_i[c] through a SYNC_LEVELS-deep flop chain; the last stage is the synced value S.
REQ-016 Each channel SHALL hold a filtered level F (data_o[c]) and a stability counter of width $clog2(FILTER_CYCLES+1).
REQ-017 The stability counter SHALL behave as follows:
- S != F: the counter increments each cycle.
- S == F: the counter is 0 on the next cycle.
REQ-018 When S != F and the counter equals FILTER_CYCLES-1, F SHALL take S on that clock edge and the counter SHALL return to 0.
REQ-019 A data_i change held stable SHALL appear on data_o exactly SYNC_LEVELS+FILTER_CYCLES clock edges after the first edge that samples it.
REQ-020 A pulse on S shorter than FILTER_CYCLES cycles SHALL leave F, edge_o, pending_o and count_o unchanged.
REQ-021 A transition of F SHALL be qualified as follows:
- 0->1: qualified when the mode is 01 or 11.
- 1->0: qualified when the mode is 10 or 11.
- Mode 00: never qualified, but F still tracks S.
REQ-022 edge_o[c] SHALL be registered and high for exactly the one cycle in which data_o[c] first shows the qualified new value.
REQ-023 pending_o[c] SHALL set on a qualified edge and clear on clear_i[c]; when both occur in the same cycle, set wins.
REQ-024 The channel-c count SHALL increment by 1 per qualified edge and saturate at 2^CNT_WIDTH-1.
REQ-025 clear_i[c] alone SHALL zero the channel-c count; clear_i[c] together with a qualified edge in the same cycle SHALL load the count with 1.
REQ-026 A mode_i change SHALL affect only transitions of F occurring after it is sampled; it SHALL NOT alter pending_o or count_o.
REQ-027 Channels SHALL be fully independent, and simultaneous edges on all channels SHALL all be reported in the same cycle.
REQ-028 irq_o SHALL be combinational from the pending_o flops, with no additional latency.

Reset
REQ-029 Asserting arst_ni low SHALL immediately clear all sync flops, F, stability counters, edge_o, pending_o, count_o and irq_o to 0, including mid-filter or mid-pulse.
REQ-030 An input held high through reset release SHALL be reported as a rising edge SYNC_LEVELS+FILTER_CYCLES edges after release, if the mode qualifies it.

Verification (CHANNELS=4, SYNC_LEVELS=2, FILTER_CYCLES=4, CNT_WIDTH=8)
REQ-031 Bench SHALL check the basic rising edge: ch0 mode 01, data_i[0] 0->1 held -> data_o[0]=1 and edge_o[0]=1 for one cycle at edge 6; pending_o[0]=1, count=1, irq_o=1.
REQ-032 Bench SHALL check glitch rejection: ch1 mode 11, data_i[1] high for 3 cycles, then high for 4 cycles -> first pulse gives no edge and no data_o change; second pulse gives a rising then a falling edge, count=2.
REQ-033 Bench SHALL check mode filtering: ch2 mode 10, full 0->1->0 pulse -> no edge_o on the rise, edge_o on the fall, count=1; mode 00 repeat -> data_o toggles, count stays 1.
REQ-034 Bench SHALL check simultaneous clear and edge: clear_i[0] asserted in the same cycle as a qualified edge with count=5 -> pending_o[0] stays 1, count=1; clear_i alone -> pending 0, count 0, irq_o 0.
REQ-035 Bench SHALL check saturation: 300 qualified edges on ch3 -> count=255, no wrap.
REQ-036 Bench SHALL check reset mid-operation: arst_ni asserted 2 cycles into a filter window -> all outputs 0 at once; input still high after release -> edge at edge 6 after release.

Source files
------------

// File: rtl/edge_monitor.sv
// Multi-channel input monitor: synchronise, debounce, detect mode-selected edges,
// and keep per-channel sticky flags and saturating edge counts.
module edge_monitor_ch #(
  parameter int SYNC_LEVELS   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                 clk_i,
  input  logic                 arst_ni,
  input  logic                 data_i,
  input  logic [1:0]           mode_i,
  input  logic                 clear_i,
  output logic                 data_o,
  output logic                 edge_o,
  output logic                 pending_o,
  output logic [CNT_WIDTH-1:0] count_o
);
  localparam int FCW = $clog2(FILTER_CYCLES + 1);
  localparam logic [FCW-1:0] FLT_LAST = FCW'(FILTER_CYCLES - 1);

  logic [SYNC_LEVELS-1:0] sync_q;
  logic                   sync_s;
  logic                   filt_q, filt_d;
  logic [FCW-1:0]         stab_q, stab_d;
  logic                   upd, qual;
  logic                   edge_q, pend_q, pend_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

  assign sync_s = sync_q[SYNC_LEVELS-1];

  // Stability counter only runs while the synced value disagrees with the filtered one.
  always_comb begin
    filt_d = filt_q;
    stab_d = '0;
    upd    = 1'b0;
    if (sync_s != filt_q) begin
      if (stab_q == FLT_LAST) begin
        upd    = 1'b1;
        filt_d = sync_s;
      end else begin
        stab_d = stab_q + FCW'(1);
      end
    end
  end

  // mode_i[0] qualifies rising, mode_i[1] falling; sync_s is the new level.
  assign qual = upd & (sync_s ? mode_i[0] : mode_i[1]);

  always_comb begin
    pend_d = qual | (pend_q & ~clear_i);
    cnt_d  = cnt_q;
    if (qual) begin
      if (clear_i)     cnt_d = CNT_WIDTH'(1);
      else if (~&cnt_q) cnt_d = cnt_q + CNT_WIDTH'(1);
    end else if (clear_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      sync_q <= '0;
      filt_q <= 1'b0;
      stab_q <= '0;
      edge_q <= 1'b0;
      pend_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_LEVELS-2:0], data_i};
      filt_q <= filt_d;
      stab_q <= stab_d;
      edge_q <= qual;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data_o    = filt_q;
  assign edge_o    = edge_q;
  assign pending_o = pend_q;
  assign count_o   = cnt_q;
endmodule

module edge_monitor #(
  parameter int CHANNELS      = 4,
  parameter int SYNC_LEVELS   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                          clk_i,
  input  logic                          arst_ni,
  input  logic [CHANNELS-1:0]           data_i,
  input  logic [2*CHANNELS-1:0]         mode_i,
  input  logic [CHANNELS-1:0]           clear_i,
  output logic [CHANNELS-1:0]           data_o,
  output logic [CHANNELS-1:0]           edge_o,
  output logic [CHANNELS-1:0]           pending_o,
  output logic [CHANNELS*CNT_WIDTH-1:0] count_o,
  output logic                          irq_o
);
  logic [CHANNELS-1:0][CNT_WIDTH-1:0] cnt;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    edge_monitor_ch #(
      .SYNC_LEVELS  (SYNC_LEVELS),
      .FILTER_CYCLES(FILTER_CYCLES),
      .CNT_WIDTH    (CNT_WIDTH)
    ) u_ch (
      .clk_i    (clk_i),
      .arst_ni  (arst_ni),
      .data_i   (data_i[c]),
      .mode_i   (mode_i[2*c +: 2]),
      .clear_i  (clear_i[c]),
      .data_o   (data_o[c]),
      .edge_o   (edge_o[c]),
      .pending_o(pending_o[c]),
      .count_o  (cnt[c])
    );
  end

  assign count_o = cnt;
  assign irq_o   = |pending_o;
endmodule

// File: tb/tb_edge_monitor.sv
// Directed bench for edge_monitor: per-cycle vector table plus multi-cycle sequences.
module tb_edge_monitor;
  logic        clk_i = 1'b0;
  logic        arst_ni;
  logic [3:0]  data_i, clear_i;
  logic [7:0]  mode_i;
  logic [3:0]  data_o, edge_o, pending_o;
  logic [31:0] count_o;
  logic        irq_o;

  int errs = 0, checks = 0;

  edge_monitor #(.CHANNELS(4), .SYNC_LEVELS(2), .FILTER_CYCLES(4), .CNT_WIDTH(8)) dut (
    .clk_i(clk_i), .arst_ni(arst_ni), .data_i(data_i), .mode_i(mode_i), .clear_i(clear_i),
    .data_o(data_o), .edge_o(edge_o), .pending_o(pending_o), .count_o(count_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [3:0] d;
    logic [3:0] clr;
    logic [3:0] ed;
    logic [3:0] ee;
    logic [3:0] ep;
    logic       ei;
    logic [7:0] ec0;
  } vec_t;

  vec_t tbl [16];

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, ".data"}, {28'd0, data_o}, 32'd0);
    check({name, ".edge"}, {28'd0, edge_o}, 32'd0);
    check({name, ".pend"}, {28'd0, pending_o}, 32'd0);
    check({name, ".irq"}, {31'd0, irq_o}, 32'd0);
    check({name, ".cnt"}, count_o, 32'd0);
  endtask

  int ne, nrise;

  initial begin
    // ch0 mode 01 throughout the table; others off.
    tbl[0] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 8'd0};
    for (int i = 1; i <= 5; i++) tbl[i] = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 8'd0};
    tbl[6] = '{4'h1, 4'h0, 4'h1, 4'h1, 4'h1, 1'b1, 8'd1};
    tbl[7] = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h1, 1'b1, 8'd1};
    for (int i = 8; i <= 12; i++) tbl[i] = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h1, 1'b1, 8'd1};
    tbl[13] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 1'b1, 8'd1};
    tbl[14] = '{4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 8'd0};
    tbl[15] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 8'd0};

    arst_ni = 1'b0; data_i = '0; clear_i = '0; mode_i = 8'h01;
    tick(2);
    check_all_zero("reset");
    arst_ni = 1'b1;

    for (int i = 0; i < 16; i++) begin
      data_i = tbl[i].d; clear_i = tbl[i].clr;
      tick();
      check($sformatf("tbl%0d.data", i), {28'd0, data_o}, {28'd0, tbl[i].ed});
      check($sformatf("tbl%0d.edge", i), {28'd0, edge_o}, {28'd0, tbl[i].ee});
      check($sformatf("tbl%0d.pend", i), {28'd0, pending_o}, {28'd0, tbl[i].ep});
      check($sformatf("tbl%0d.irq", i), {31'd0, irq_o}, {31'd0, tbl[i].ei});
      check($sformatf("tbl%0d.cnt", i), count_o, {24'd0, tbl[i].ec0});
    end
    clear_i = '0;

    // Clear coinciding with a qualified edge: set wins, count loads 1.
    for (int k = 0; k < 5; k++) begin
      data_i[0] = 1'b1; tick(6);
      data_i[0] = 1'b0; tick(6);
    end
    check("clredge.cnt5", count_o, 32'd5);
    data_i[0] = 1'b1; tick(5);
    clear_i[0] = 1'b1; tick();
    clear_i[0] = 1'b0;
    check("clredge.edge", {28'd0, edge_o}, 32'h1);
    check("clredge.pend", {28'd0, pending_o}, 32'h1);
    check("clredge.cnt", count_o, 32'd1);
    tick(3);
    clear_i[0] = 1'b1; tick();
    clear_i[0] = 1'b0;
    check("clronly.pend", {28'd0, pending_o}, 32'h0);
    check("clronly.cnt", count_o, 32'd0);
    check("clronly.irq", {31'd0, irq_o}, 32'd0);

    // Glitch rejection on ch1, mode 11.
    mode_i[3:2] = 2'b11;
    ne = 0;
    data_i[1] = 1'b1; tick(); ne += edge_o[1]; tick(); ne += edge_o[1]; tick(); ne += edge_o[1];
    data_i[1] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      ne += edge_o[1];
      if (data_o[1]) ne += 100;
    end
    check("glitch3.none", ne, 32'd0);
    check("glitch3.cnt", count_o[15:8], 32'd0);
    ne = 0; nrise = 0;
    data_i[1] = 1'b1; tick(4);
    data_i[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); ne += edge_o[1];
      if (edge_o[1] && data_o[1]) nrise++;
    end
    for (int i = 0; i < 12; i++) begin
      tick(); ne += edge_o[1];
    end
    check("glitch4.edges", ne, 32'd2);
    check("glitch4.rise", nrise, 32'd1);
    check("glitch4.cnt", count_o[15:8], 32'd2);
    check("glitch4.pend", {31'd0, pending_o[1]}, 32'd1);

    // Mode filtering on ch2: falling only, then off.
    mode_i[5:4] = 2'b10;
    data_i[2] = 1'b1; tick(6);
    check("mode10.rise.data", {31'd0, data_o[2]}, 32'd1);
    check("mode10.rise.edge", {31'd0, edge_o[2]}, 32'd0);
    check("mode10.rise.pend", {31'd0, pending_o[2]}, 32'd0);
    data_i[2] = 1'b0; tick(6);
    check("mode10.fall.data", {31'd0, data_o[2]}, 32'd0);
    check("mode10.fall.edge", {31'd0, edge_o[2]}, 32'd1);
    check("mode10.cnt", count_o[23:16], 32'd1);
    mode_i[5:4] = 2'b00;
    ne = 0;
    data_i[2] = 1'b1;
    for (int i = 0; i < 6; i++) begin tick(); ne += edge_o[2]; end
    check("mode00.rise.data", {31'd0, data_o[2]}, 32'd1);
    data_i[2] = 1'b0;
    for (int i = 0; i < 6; i++) begin tick(); ne += edge_o[2]; end
    check("mode00.fall.data", {31'd0, data_o[2]}, 32'd0);
    check("mode00.edges", ne, 32'd0);
    check("mode00.cnt", count_o[23:16], 32'd1);
    check("mode00.pend", {31'd0, pending_o[2]}, 32'd1);

    // Saturation on ch3, mode 11, 300 toggles.
    mode_i[7:6] = 2'b11;
    for (int i = 1; i <= 300; i++) begin
      data_i[3] = ~data_i[3];
      tick(6);
      if (i == 254) check("sat.254", count_o[31:24], 32'd254);
      if (i == 256) check("sat.256", count_o[31:24], 32'd255);
    end
    check("sat.300", count_o[31:24], 32'd255);
    check("sat.irq", {31'd0, irq_o}, 32'd1);

    // Asynchronous reset two cycles into ch0's filter window.
    clear_i = '0;
    data_i[0] = 1'b0; tick(8);
    data_i[0] = 1'b1; tick(4);
    arst_ni = 1'b0;
    #1;
    check_all_zero("rst.async");
    tick(2);
    arst_ni = 1'b1;
    tick(5);
    check("rst.rel5.data", {28'd0, data_o}, 32'h0);
    tick();
    check("rst.rel6.data", {28'd0, data_o}, 32'h1);
    check("rst.rel6.edge", {28'd0, edge_o}, 32'h1);
    check("rst.rel6.cnt", count_o, 32'd1);
    tick();
    check("rst.rel7.edge", {28'd0, edge_o}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
